bdd_node_loader: RTL and testbench

- Write-side counterpart of the tree-walk datapath: takes a byte stream of decision-tree node records and programs the node memories through their write port (in_addr / we1 / ram1_data_in / ram2_data_in).
- Each record becomes one coefficient/threshold word (RAM1) plus one child-pointer word (RAM2), written to the same node address.
- Sits between the host byte interface and the two node SRAMs. The walker must not run while busy is high.

---
 rtl/bdd_node_loader.sv | 165 ++++++++++++++++
 tb/tb_bdd_node_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bdd_node_loader.sv
// rtl/bdd_node_loader.sv - byte-stream loader that programs the tree-walk node SRAMs
// Optional trailing XOR checksum byte: define BDD_LOADER_CHECKSUM_EN.
module bdd_node_loader #(
  parameter int RAM1_DATA_WIDTH = 34,
  parameter int RAM2_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH      = 5,
  parameter int DEPTH           = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 s_data,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic                       abort,
  output logic [ADDR_WIDTH-1:0]      wr_addr,
  output logic                       we,
  output logic [RAM1_DATA_WIDTH-1:0] ram1_data,
  output logic [RAM2_DATA_WIDTH-1:0] ram2_data,
  output logic                       busy,
  output logic                       done,
  output logic                       err,
  output logic [ADDR_WIDTH:0]        nodes_loaded
);
  // Only the low RAM1 bits of bytes 0-4 plus byte 5 are ever needed, so the
  // discarded top bits of the 40-bit field are never stored.
  localparam int         ASM_W    = RAM1_DATA_WIDTH + 8;
  localparam logic [8:0] LP_DEPTH = 9'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_REC, S_WRITE, S_FIN, S_CSUM} state_t;

  state_t                r_state;
  logic [ASM_W-1:0]      r_asm;
  logic [2:0]            r_idx;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_n;
`ifdef BDD_LOADER_CHECKSUM_EN
  logic [7:0]            r_csum;
`endif
  logic                  w_accept;
  logic [ADDR_WIDTH:0]   w_loaded_inc;

  assign w_accept     = s_valid && s_ready;
  assign w_loaded_inc = nodes_loaded + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_asm        <= '0;
      r_idx        <= '0;
      r_addr       <= '0;
      r_n          <= '0;
`ifdef BDD_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
      s_ready      <= 1'b1;
      wr_addr      <= '0;
      we           <= 1'b0;
      ram1_data    <= '0;
      ram2_data    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      nodes_loaded <= '0;
    end else begin
      we   <= 1'b0;
      done <= 1'b0;
      if (abort) begin
        // The write strobed this cycle lands in the SRAM, so it is counted.
        if (r_state != S_IDLE)  err          <= 1'b1;
        if (r_state == S_WRITE) nodes_loaded <= w_loaded_inc;
        r_state <= S_IDLE;
        busy    <= 1'b0;
        s_ready <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept && s_data == 8'hA5) begin
              r_state      <= S_COUNT;
              busy         <= 1'b1;
              err          <= 1'b0;
              nodes_loaded <= '0;
`ifdef BDD_LOADER_CHECKSUM_EN
              r_csum       <= '0;
`endif
            end
          end
          S_COUNT: begin
            if (w_accept) begin
              if (s_data == 8'h00 || {1'b0, s_data} > LP_DEPTH) begin
                err     <= 1'b1;
                busy    <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                r_n     <= s_data[ADDR_WIDTH:0];
                r_addr  <= '0;
                r_idx   <= '0;
                r_state <= S_REC;
              end
            end
          end
          S_REC: begin
            if (w_accept) begin
              r_asm <= {r_asm[ASM_W-9:0], s_data};
`ifdef BDD_LOADER_CHECKSUM_EN
              r_csum <= r_csum ^ s_data;
`endif
              if (r_idx == 3'd6) begin
                r_state   <= S_WRITE;
                we        <= 1'b1;
                s_ready   <= 1'b0;
                wr_addr   <= r_addr;
                ram1_data <= r_asm[ASM_W-1:8];
                ram2_data <= RAM2_DATA_WIDTH'({r_asm[7:0], s_data});
              end else begin
                r_idx <= r_idx + 3'd1;
              end
            end
          end
          S_WRITE: begin
            nodes_loaded <= w_loaded_inc;
            if (w_loaded_inc == r_n) begin
`ifdef BDD_LOADER_CHECKSUM_EN
              r_state <= S_CSUM;
              s_ready <= 1'b1;
`else
              r_state <= S_FIN;
              done    <= 1'b1;
`endif
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_idx   <= '0;
              r_state <= S_REC;
              s_ready <= 1'b1;
            end
          end
          S_FIN: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
`ifdef BDD_LOADER_CHECKSUM_EN
          S_CSUM: begin
            if (w_accept) begin
              if (s_data != r_csum) begin
                err     <= 1'b1;
                busy    <= 1'b0;
                r_state <= S_IDLE;
              end else begin
                done    <= 1'b1;
                s_ready <= 1'b0;
                r_state <= S_FIN;
              end
            end
          end
`endif
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
            s_ready <= 1'b1;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bdd_node_loader.sv
// tb/tb_bdd_node_loader.sv - randomized self-checking bench for bdd_node_loader
module tb_bdd_node_loader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        abort;
  logic [4:0]  wr_addr;
  logic        we;
  logic [33:0] ram1_data;
  logic [15:0] ram2_data;
  logic        busy;
  logic        done;
  logic        err;
  logic [5:0]  nodes_loaded;

  bdd_node_loader dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .abort(abort), .wr_addr(wr_addr), .we(we), .ram1_data(ram1_data), .ram2_data(ram2_data),
    .busy(busy), .done(done), .err(err), .nodes_loaded(nodes_loaded)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [4:0]  addr;
    logic [33:0] d1;
    logic [15:0] d2;
    logic        rdy;
  } wev_t;

  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  wev_t       we_q[$];
  int         done_q[$];
  logic [7:0] g_rec[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (we === 1'b1) we_q.push_back('{cyc, wr_addr, ram1_data, ram2_data, s_ready});
      if (done === 1'b1) done_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  function automatic logic [33:0] exp1(input int base);
    logic [39:0] v;
    v = '0;
    for (int j = 0; j < 5; j++) v = v * 256 + 40'(g_rec[base + j]);
    return v[33:0];
  endfunction

  function automatic logic [15:0] exp2(input int base);
    return 16'(g_rec[base + 5]) * 256 + 16'(g_rec[base + 6]);
  endfunction

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Entered and left on a negedge; acc_cyc is the cycle in which the byte was taken.
  task automatic send_byte(input logic [7:0] b, output int acc_cyc);
    int guard;
    guard = 0;
    s_data = b;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) begin
      check("accept_timeout", 64'(guard), 64'd0);
      acc_cyc = -1;
    end else begin
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
    end
    s_valid = 1'b0;
  endtask

  task automatic fill_rec(input int n);
    g_rec.delete();
    for (int i = 0; i < 7 * n; i++) g_rec.push_back(8'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(s_ready), 64'd1);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_we"}, 64'(we), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_err"}, 64'(err), 64'd0);
    check({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
    check({tag, "_ram1"}, 64'(ram1_data), 64'd0);
    check({tag, "_ram2"}, 64'(ram2_data), 64'd0);
    check({tag, "_nodes"}, 64'(nodes_loaded), 64'd0);
  endtask

  // Sends a full frame whose record bytes are in g_rec and checks every write against the frame.
  task automatic run_frame(input int n, input bit gaps, input bit bad_csum);
    int         ac;
    int         exp_cyc[$];
    int         fin_cyc;
    logic [7:0] csum;
    we_q.delete();
    done_q.delete();
    csum = '0;
    send_byte(8'hA5, ac);
    check("err_clear_on_a5", 64'(err), 64'd0);
    send_byte(8'(n), ac);
    for (int i = 0; i < 7 * n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send_byte(g_rec[i], ac);
      csum ^= g_rec[i];
      if (i % 7 == 6) exp_cyc.push_back(ac);
    end
    fin_cyc = exp_cyc[n - 1] + 1;
`ifdef BDD_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (csum ^ 8'h5A) : csum, ac);
    fin_cyc = ac;
`endif
    idle(5);
    check("we_count", 64'(we_q.size()), 64'(n));
    for (int i = 0; i < n && i < we_q.size(); i++) begin
      check("we_addr", 64'(we_q[i].addr), 64'(i));
      check("we_ram1", 64'(we_q[i].d1), 64'(exp1(7 * i)));
      check("we_ram2", 64'(we_q[i].d2), 64'(exp2(7 * i)));
      check("we_latency", 64'(we_q[i].cyc), 64'(exp_cyc[i]));
      check("we_s_ready", 64'(we_q[i].rdy), 64'd0);
    end
    check("done_count", 64'(done_q.size()), bad_csum ? 64'd0 : 64'd1);
    if (!bad_csum && done_q.size() > 0) check("done_cycle", 64'(done_q[0]), 64'(fin_cyc));
    check("err_after", 64'(err), bad_csum ? 64'd1 : 64'd0);
    check("nodes_loaded", 64'(nodes_loaded), 64'(n));
    check("busy_after", 64'(busy), 64'd0);
    check("s_ready_after", 64'(s_ready), 64'd1);
  endtask

  task automatic bad_count(input logic [7:0] n);
    int ac;
    we_q.delete();
    done_q.delete();
    send_byte(8'hA5, ac);
    send_byte(n, ac);
    idle(3);
    check("badn_err", 64'(err), 64'd1);
    check("badn_we", 64'(we_q.size()), 64'd0);
    check("badn_busy", 64'(busy), 64'd0);
    check("badn_nodes", 64'(nodes_loaded), 64'd0);
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    int         ac;
    logic [7:0] junk;
    rst_n = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    g_rec = '{8'h00, 8'h00, 8'h00, 8'h04, 8'h0A, 8'h81, 8'h23};
    run_frame(1, 1'b0, 1'b0);
    check("tp_ram1", 64'(ram1_data), 64'h00000040A);
    check("tp_ram2", 64'(ram2_data), 64'h8123);
    check("tp_addr", 64'(wr_addr), 64'd0);

    fill_rec(3);
    run_frame(3, 1'b0, 1'b0);

    bad_count(8'h00);
    bad_count(8'h21);
    bad_count(8'($urandom_range(33, 255)));

    for (int f = 0; f < 6; f++) begin
      int n;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk, ac);
      end
      n = $urandom_range(1, 6);
      fill_rec(n);
      run_frame(n, 1'b1, 1'b0);
    end

    fill_rec(32);
    run_frame(32, 1'b1, 1'b0);
    check("full_last_addr", 64'(wr_addr), 64'd31);

    // abort after 4 bytes of record 1 of a 2-node frame
    fill_rec(2);
    we_q.delete();
    done_q.delete();
    send_byte(8'hA5, ac);
    send_byte(8'h02, ac);
    for (int i = 0; i < 11; i++) send_byte(g_rec[i], ac);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_err", 64'(err), 64'd1);
    check("abort_we", 64'(we), 64'd0);
    check("abort_s_ready", 64'(s_ready), 64'd1);
    idle(3);
    check("abort_we_count", 64'(we_q.size()), 64'd1);
    if (we_q.size() > 0) begin
      check("abort_we_addr", 64'(we_q[0].addr), 64'd0);
      check("abort_we_ram1", 64'(we_q[0].d1), 64'(exp1(0)));
    end
    check("abort_done", 64'(done_q.size()), 64'd0);
    check("abort_nodes", 64'(nodes_loaded), 64'd1);

    // reset mid-record
    fill_rec(1);
    send_byte(8'hA5, ac);
    send_byte(8'h01, ac);
    for (int i = 0; i < 3; i++) send_byte(g_rec[i], ac);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill_rec(1);
    run_frame(1, 1'b1, 1'b0);

`ifdef BDD_LOADER_CHECKSUM_EN
    fill_rec(2);
    run_frame(2, 1'b0, 1'b1);
    fill_rec(1);
    run_frame(1, 1'b0, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
